// File: rtl/muller_c_handshake_mon_if.sv
// Signal bundle between a Muller C-element stage and its synchronous monitor.
// master drives the element signals and clear; slave is the monitor.
interface muller_c_handshake_mon_if #(
  parameter int CNT_W = 16
);
  logic             c_a;
  logic             c_b;
  logic             c_q;
  logic             clr;
  logic             q_sync;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;
  logic             err_glitch;
  logic             err_timeout;

  modport master (
    output c_a, c_b, c_q, clr,
    input  q_sync, busy, cycle_count, err_glitch, err_timeout
  );

  modport slave (
    input  c_a, c_b, c_q, clr,
    output q_sync, busy, cycle_count, err_glitch, err_timeout
  );
endinterface

// File: rtl/muller_c_handshake_mon.sv
// Synchronous four-phase monitor for a Muller C-element: counts q cycles, flags glitches.
// Define MULLER_MON_TIMEOUT_EN to build the follow-timeout timer and err_timeout flag.
module muller_c_handshake_mon #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  muller_c_handshake_mon_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HIGH   = 2'd2,
    ST_DISARM = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Out-of-range parameters are rejected at elaboration.
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_param_check
    $error("muller_c_handshake_mon: SYNC_STAGES or TIMEOUT out of range");
  end

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [SYNC_STAGES-1:0] q_sync_q, q_sync_d;
  logic                   as_prev_q, as_prev_d;
  logic                   bs_prev_q, bs_prev_d;
  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_glitch_q, err_glitch_d;

  logic as_s, bs_s, qs_s;
  logic agree1_s, agree0_s, prev_agree1_s, prev_agree0_s;
  logic inc_s, glitch_s;

  // Synchronizer shift and agreement terms.
  always_comb begin
    a_sync_d      = {a_sync_q[SYNC_STAGES-2:0], mon.c_a};
    b_sync_d      = {b_sync_q[SYNC_STAGES-2:0], mon.c_b};
    q_sync_d      = {q_sync_q[SYNC_STAGES-2:0], mon.c_q};
    as_s          = a_sync_q[SYNC_STAGES-1];
    bs_s          = b_sync_q[SYNC_STAGES-1];
    qs_s          = q_sync_q[SYNC_STAGES-1];
    as_prev_d     = as_s;
    bs_prev_d     = bs_s;
    agree1_s      = as_s & bs_s;
    agree0_s      = ~as_s & ~bs_s;
    prev_agree1_s = as_prev_q & bs_prev_q;
    prev_agree0_s = ~as_prev_q & ~bs_prev_q;
  end

  // Four-phase next-state logic; q moving is checked before input agreement.
  always_comb begin
    state_d  = state_q;
    inc_s    = 1'b0;
    glitch_s = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (qs_s) begin
          state_d  = ST_HIGH;
          glitch_s = ~(agree1_s | prev_agree1_s);
        end else if (agree1_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_ARMED: begin
        if (qs_s) begin
          state_d = ST_HIGH;
        end else if (!agree1_s) begin
          state_d = ST_LOW;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_HIGH: begin
        if (!qs_s) begin
          state_d  = ST_LOW;
          glitch_s = ~(agree0_s | prev_agree0_s);
        end else if (agree0_s) begin
          state_d = ST_DISARM;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_DISARM: begin
        if (!qs_s) begin
          state_d = ST_LOW;
          inc_s   = 1'b1;
        end else if (!agree0_s) begin
          state_d = ST_HIGH;
        end else begin
          state_d = ST_DISARM;
        end
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase
  end

  // Counter and sticky glitch flag; clr overrides same-cycle updates.
  always_comb begin
    busy_d = (state_d == ST_ARMED) || (state_d == ST_DISARM);
    if (mon.clr) begin
      cnt_d        = {CNT_W{1'b0}};
      err_glitch_d = 1'b0;
    end else begin
      if (inc_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
      err_glitch_d = err_glitch_q | glitch_s;
    end
  end

  // All synchronizer, FSM and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q     <= {SYNC_STAGES{1'b0}};
      b_sync_q     <= {SYNC_STAGES{1'b0}};
      q_sync_q     <= {SYNC_STAGES{1'b0}};
      as_prev_q    <= 1'b0;
      bs_prev_q    <= 1'b0;
      state_q      <= ST_LOW;
      busy_q       <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      err_glitch_q <= 1'b0;
    end else begin
      a_sync_q     <= a_sync_d;
      b_sync_q     <= b_sync_d;
      q_sync_q     <= q_sync_d;
      as_prev_q    <= as_prev_d;
      bs_prev_q    <= bs_prev_d;
      state_q      <= state_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      err_glitch_q <= err_glitch_d;
    end
  end

`ifdef MULLER_MON_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

  logic [15:0] timer_q, timer_d;
  logic        err_timeout_q, err_timeout_d;
  logic        stay_busy_s;

  // Timer restarts on entry to a waiting state and saturates at the limit.
  always_comb begin
    stay_busy_s = busy_d && (state_d == state_q);
    if (mon.clr) begin
      timer_d       = 16'd0;
      err_timeout_d = 1'b0;
    end else begin
      if (!stay_busy_s) begin
        timer_d = 16'd0;
      end else if (timer_q != TMO_LIM) begin
        timer_d = timer_q + 16'd1;
      end else begin
        timer_d = timer_q;
      end
      if (stay_busy_s && (timer_d == TMO_LIM)) begin
        err_timeout_d = 1'b1;
      end else begin
        err_timeout_d = err_timeout_q;
      end
    end
  end

  // Timer and sticky timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q       <= 16'd0;
      err_timeout_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign mon.err_timeout = err_timeout_q;
`else
  assign mon.err_timeout = 1'b0;
`endif

  assign mon.q_sync      = q_sync_q[SYNC_STAGES-1];
  assign mon.busy        = busy_q;
  assign mon.cycle_count = cnt_q;
  assign mon.err_glitch  = err_glitch_q;

endmodule

// File: tb/tb_muller_c_handshake_mon.sv
// Randomized self-checking bench for muller_c_handshake_mon (SYNC_STAGES=2, CNT_W=8, TIMEOUT=10).
module tb_muller_c_handshake_mon;
  localparam int SS   = 2;
  localparam int CW   = 8;
  localparam int TMO  = 10;
  localparam int CMAX = (1 << CW) - 1;
`ifdef MULLER_MON_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_count = 0;

  muller_c_handshake_mon_if #(.CNT_W(CW)) mif ();

  muller_c_handshake_mon #(
    .SYNC_STAGES(SS),
    .CNT_W      (CW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (mif)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a and b to v, either together or one cycle apart.
  task automatic set_pair(input logic v);
    if ($urandom_range(0, 1) == 0) begin
      mif.c_a = v;
      mif.c_b = v;
    end else begin
      if ($urandom_range(0, 1) == 0) mif.c_a = v;
      else mif.c_b = v;
      tick(1);
      mif.c_a = v;
      mif.c_b = v;
    end
  endtask

  task automatic legal_cycle();
    set_pair(1'b1);
    tick($urandom_range(2, 4));
    mif.c_q = 1'b1;
    tick($urandom_range(2, 4));
    set_pair(1'b0);
    tick($urandom_range(2, 4));
    mif.c_q = 1'b0;
    tick($urandom_range(4, 6));
    exp_count = (exp_count < CMAX) ? exp_count + 1 : CMAX;
  endtask

  task automatic pulse_clr();
    mif.clr = 1'b1;
    tick(1);
    mif.clr = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mif.c_a = 1'b0; mif.c_b = 1'b0; mif.c_q = 1'b0; mif.clr = 1'b0;
    tick(3);
    n_checks++; if (mif.q_sync !== 1'b0) begin n_fail++; $display("FAIL reset_q_sync: got %b want 0", mif.q_sync); end
    n_checks++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
    n_checks++; if (mif.cycle_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", mif.cycle_count); end
    n_checks++; if (mif.err_glitch !== 1'b0) begin n_fail++; $display("FAIL reset_glitch: got %b want 0", mif.err_glitch); end
    n_checks++; if (mif.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", mif.err_timeout); end
    rst_n = 1'b1;
    tick(2);
    exp_count = 0;
  endtask

  task automatic test_basic_cycle();
    mif.c_a = 1'b1; mif.c_b = 1'b1;
    tick(2);
    n_checks++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_early: got %b want 0", mif.busy); end
    tick(1);
    n_checks++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_armed: got %b want 1", mif.busy); end
    mif.c_q = 1'b1;
    tick(2);
    n_checks++; if (mif.q_sync !== 1'b1) begin n_fail++; $display("FAIL basic_q_sync_rise: got %b want 1", mif.q_sync); end
    tick(1);
    n_checks++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_high: got %b want 0", mif.busy); end
    mif.c_a = 1'b0; mif.c_b = 1'b0;
    tick(3);
    n_checks++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_disarm: got %b want 1", mif.busy); end
    mif.c_q = 1'b0;
    tick(2);
    n_checks++; if (mif.cycle_count !== 8'd0) begin n_fail++; $display("FAIL basic_count_early: got %0d want 0", mif.cycle_count); end
    tick(1);
    exp_count = 1;
    n_checks++; if (mif.cycle_count !== 8'(exp_count)) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", mif.cycle_count, exp_count); end
    n_checks++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_low: got %b want 0", mif.busy); end
    n_checks++; if (mif.err_glitch !== 1'b0) begin n_fail++; $display("FAIL basic_glitch: got %b want 0", mif.err_glitch); end
    tick(2);
  endtask

  task automatic test_random_cycles();
    int n;
    n = $urandom_range(8, 16);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        legal_cycle();
      end else begin
        set_pair(1'b1);
        tick($urandom_range(3, 5));
        if ($urandom_range(0, 1) == 0) mif.c_a = 1'b0;
        else mif.c_b = 1'b0;
        tick(4);
        n_checks++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL withdraw_busy: got %b want 0", mif.busy); end
        mif.c_a = 1'b0; mif.c_b = 1'b0;
        tick(3);
      end
      n_checks++; if (mif.cycle_count !== 8'(exp_count)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, mif.cycle_count, exp_count); end
      n_checks++; if (mif.err_glitch !== 1'b0) begin n_fail++; $display("FAIL rand_glitch[%0d]: got %b want 0", i, mif.err_glitch); end
    end
    n_checks++; if (mif.err_timeout !== 1'b0) begin n_fail++; $display("FAIL rand_timeout: got %b want 0", mif.err_timeout); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CMAX + 3; i++) legal_cycle();
    n_checks++; if (mif.cycle_count !== 8'(exp_count)) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", mif.cycle_count, exp_count); end
    pulse_clr();
    n_checks++; if (mif.cycle_count !== 8'd0) begin n_fail++; $display("FAIL sat_clr: got %0d want 0", mif.cycle_count); end
  endtask

  task automatic test_glitch();
    int base;
    base = exp_count;
    mif.c_a = 1'b1; mif.c_b = 1'b0;
    tick(3);
    mif.c_q = 1'b1;
    tick(2);
    n_checks++; if (mif.err_glitch !== 1'b0) begin n_fail++; $display("FAIL glitch_early: got %b want 0", mif.err_glitch); end
    tick(1);
    n_checks++; if (mif.err_glitch !== 1'b1) begin n_fail++; $display("FAIL glitch_rise: got %b want 1", mif.err_glitch); end
    n_checks++; if (mif.cycle_count !== 8'(base)) begin n_fail++; $display("FAIL glitch_count: got %0d want %0d", mif.cycle_count, base); end
    pulse_clr();
    n_checks++; if (mif.err_glitch !== 1'b0) begin n_fail++; $display("FAIL glitch_clr: got %b want 0", mif.err_glitch); end
    // In HIGH, dropping a reaches agree0 and a following q fall is a legal completion.
    mif.c_a = 1'b0;
    tick(3);
    n_checks++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_disarm_busy: got %b want 1", mif.busy); end
    mif.c_q = 1'b0;
    tick(4);
    exp_count = exp_count + 1;
    n_checks++; if (mif.cycle_count !== 8'(exp_count)) begin n_fail++; $display("FAIL glitch_recover_count: got %0d want %0d", mif.cycle_count, exp_count); end
    // Falling q with inputs still split is an error and not counted.
    mif.c_a = 1'b1; mif.c_b = 1'b1;
    tick(3);
    mif.c_q = 1'b1;
    tick(4);
    mif.c_b = 1'b0;
    tick(3);
    mif.c_q = 1'b0;
    tick(4);
    n_checks++; if (mif.err_glitch !== 1'b1) begin n_fail++; $display("FAIL glitch_fall: got %b want 1", mif.err_glitch); end
    n_checks++; if (mif.cycle_count !== 8'(exp_count)) begin n_fail++; $display("FAIL glitch_fall_count: got %0d want %0d", mif.cycle_count, exp_count); end
    mif.c_a = 1'b0;
    tick(3);
    pulse_clr();
    // An error coinciding with clr is dropped.
    mif.c_q = 1'b1;
    tick(2);
    mif.clr = 1'b1;
    tick(1);
    mif.clr = 1'b0;
    tick(1);
    n_checks++; if (mif.err_glitch !== 1'b0) begin n_fail++; $display("FAIL glitch_clr_wins: got %b want 0", mif.err_glitch); end
    tick(2);
    mif.c_q = 1'b0;
    tick(5);
    exp_count = 1;
    n_checks++; if (mif.cycle_count !== 8'(exp_count)) begin n_fail++; $display("FAIL glitch_clr_count: got %0d want %0d", mif.cycle_count, exp_count); end
  endtask

  task automatic test_timeout();
    logic seen;
    seen = 1'b0;
    mif.c_a = 1'b1; mif.c_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!seen) begin
        tick(1);
        seen = mif.busy;
      end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_wait: got %b want 1", seen); end
    tick(TMO - 1);
    n_checks++; if (mif.err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", mif.err_timeout); end
    tick(1);
    n_checks++; if (mif.err_timeout !== TMO_EN) begin n_fail++; $display("FAIL tmo_set: got %b want %b", mif.err_timeout, TMO_EN); end
    n_checks++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL tmo_stays_armed: got %b want 1", mif.busy); end
    mif.c_a = 1'b0; mif.c_b = 1'b0;
    tick(4);
    n_checks++; if (mif.err_timeout !== TMO_EN) begin n_fail++; $display("FAIL tmo_sticky: got %b want %b", mif.err_timeout, TMO_EN); end
    pulse_clr();
    n_checks++; if (mif.err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clr: got %b want 0", mif.err_timeout); end
  endtask

  task automatic test_reset_mid();
    pulse_clr();
    for (int i = 0; i < 5; i++) legal_cycle();
    n_checks++; if (mif.cycle_count !== 8'd5) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 5", mif.cycle_count); end
    mif.c_a = 1'b1; mif.c_b = 1'b1;
    tick(3);
    mif.c_q = 1'b1;
    tick(4);
    mif.c_a = 1'b0; mif.c_b = 1'b0;
    tick(4);
    n_checks++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL mid_disarm: got %b want 1", mif.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (mif.cycle_count !== 8'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", mif.cycle_count); end
    n_checks++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", mif.busy); end
    n_checks++; if (mif.q_sync !== 1'b0) begin n_fail++; $display("FAIL mid_q_sync: got %b want 0", mif.q_sync); end
    n_checks++; if ({mif.err_glitch, mif.err_timeout} !== 2'b00) begin n_fail++; $display("FAIL mid_errs: got %b want 00", {mif.err_glitch, mif.err_timeout}); end
    mif.c_q = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    exp_count = 0;
    legal_cycle();
    n_checks++; if (mif.cycle_count !== 8'(exp_count)) begin n_fail++; $display("FAIL mid_after: got %0d want %0d", mif.cycle_count, exp_count); end
    n_checks++; if (mif.err_glitch !== 1'b0) begin n_fail++; $display("FAIL mid_after_glitch: got %b want 0", mif.err_glitch); end
  endtask

  initial begin
    test_reset();
    test_basic_cycle();
    test_random_cycles();
    test_saturation();
    test_glitch();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
